// File: rtl/hdmi_frame_scheduler_if.sv
// rtl/hdmi_frame_scheduler_if.sv - control pulses and renderer/HDMI-sink handshake bundle
interface hdmi_frame_scheduler_if;
    logic        start_req;
    logic        abort_req;
    logic        render_start;
    logic        render_done;
    logic        crc_valid;
    logic [31:0] crc_in;

    modport master (
        input  start_req,
        input  abort_req,
        input  render_done,
        input  crc_valid,
        input  crc_in,
        output render_start
    );

    modport slave (
        output start_req,
        output abort_req,
        output render_done,
        output crc_valid,
        output crc_in,
        input  render_start
    );
endinterface

// File: rtl/hdmi_frame_scheduler.sv
// rtl/hdmi_frame_scheduler.sv - frame launch/completion sequencer with CRC check and watchdog
module hdmi_frame_scheduler #(
    parameter int TIMEOUT_W = 24,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_enable,
    input  logic                 cfg_continuous,
    input  logic [CNT_W-1:0]     cfg_frame_budget,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 cfg_check_en,
    input  logic [31:0]          cfg_golden_crc,
    hdmi_frame_scheduler_if.master bus,
    output logic                 busy,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     frames_done,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic [31:0]          crc_last,
    output logic                 crc_ok,
    output logic                 timeout_flag,
    output logic                 irq_pulse
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LAUNCH      = 3'd1,
        S_WAIT_RENDER = 3'd2,
        S_WAIT_SCAN   = 3'd3,
        S_DONE        = 3'd4,
        S_ERROR       = 3'd5
    } state_t;

    state_t               state, state_next;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [CNT_W-1:0]     run_count;
    logic [CNT_W-1:0]     run_next;
    logic                 crc_pending;
    logic [31:0]          crc_hold;
    logic                 expire;
    logic                 relaunch;
    logic                 irq_q;

    always_comb begin
        run_next   = run_count + CNT_W'(1);
        expire     = (cfg_timeout != '0) && (wd_cnt == cfg_timeout - TIMEOUT_W'(1));
        relaunch   = cfg_continuous && cfg_enable &&
                     ((cfg_frame_budget == '0) || (run_next < cfg_frame_budget));
        state_next = state;
        case (state)
            S_IDLE:        if (bus.start_req && cfg_enable) state_next = S_LAUNCH;
            S_LAUNCH:      state_next = S_WAIT_RENDER;
            // A completing event on the expiry cycle takes precedence over the watchdog.
            S_WAIT_RENDER: begin
                if (bus.render_done)
                    state_next = (crc_pending || bus.crc_valid) ? S_DONE : S_WAIT_SCAN;
                else if (expire)
                    state_next = S_ERROR;
            end
            S_WAIT_SCAN: begin
                if (bus.crc_valid)
                    state_next = S_DONE;
                else if (expire)
                    state_next = S_ERROR;
            end
            S_DONE:        state_next = relaunch ? S_LAUNCH : S_IDLE;
            S_ERROR:       if (bus.start_req) state_next = cfg_enable ? S_LAUNCH : S_IDLE;
            default:       state_next = S_IDLE;
        endcase
        if (bus.abort_req)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt         <= '0;
            run_count      <= '0;
            crc_pending    <= 1'b0;
            crc_hold       <= '0;
            frames_done    <= '0;
            mismatch_count <= '0;
            crc_last       <= '0;
            crc_ok         <= 1'b1;
            timeout_flag   <= 1'b0;
            irq_q          <= 1'b0;
        end else if (bus.abort_req) begin
            run_count      <= '0;
            crc_pending    <= 1'b0;
            frames_done    <= '0;
            mismatch_count <= '0;
            crc_ok         <= 1'b1;
            timeout_flag   <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            irq_q <= (state_next == S_DONE) || (state_next == S_ERROR && state != S_ERROR);
            case (state)
                S_IDLE: if (bus.start_req && cfg_enable) run_count <= '0;
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    if (bus.crc_valid) begin
                        crc_pending <= 1'b1;
                        crc_hold    <= bus.crc_in;
                    end
                end
                S_WAIT_RENDER, S_WAIT_SCAN: begin
                    wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    if (bus.crc_valid) begin
                        crc_pending <= 1'b1;
                        crc_hold    <= bus.crc_in;
                    end
                    if (state_next == S_ERROR)
                        timeout_flag <= 1'b1;
                end
                S_DONE: begin
                    frames_done <= frames_done + CNT_W'(1);
                    run_count   <= run_next;
                    crc_last    <= crc_hold;
                    crc_pending <= 1'b0;
                    if (cfg_check_en) begin
                        crc_ok <= (crc_hold == cfg_golden_crc);
                        if (crc_hold != cfg_golden_crc && mismatch_count != '1)
                            mismatch_count <= mismatch_count + CNT_W'(1);
                    end else begin
                        crc_ok <= 1'b1;
                    end
                end
                // A stale pending CRC from the timed-out frame must not complete the relaunch.
                S_ERROR: if (bus.start_req) begin
                    timeout_flag <= 1'b0;
                    run_count    <= '0;
                    crc_pending  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.render_start = (state == S_LAUNCH);
    assign busy             = (state != S_IDLE) && (state != S_ERROR);
    assign state_o          = state;
    assign irq_pulse        = irq_q;

endmodule

// File: tb/tb_hdmi_frame_scheduler.sv
// tb/tb_hdmi_frame_scheduler.sv - scoreboard bench for hdmi_frame_scheduler
module tb_hdmi_frame_scheduler;
    localparam int CNT_W     = 16;
    localparam int TIMEOUT_W = 24;
    localparam logic [31:0] GOLDEN = 32'h0002_0500;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_enable, cfg_continuous, cfg_check_en;
    logic [CNT_W-1:0]     cfg_frame_budget;
    logic [TIMEOUT_W-1:0] cfg_timeout;
    logic [31:0]          cfg_golden_crc;
    logic                 busy, crc_ok, timeout_flag, irq_pulse;
    logic [2:0]           state_o;
    logic [CNT_W-1:0]     frames_done, mismatch_count;
    logic [31:0]          crc_last;

    hdmi_frame_scheduler_if bus_if();

    hdmi_frame_scheduler #(.TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
        .cfg_frame_budget(cfg_frame_budget), .cfg_timeout(cfg_timeout),
        .cfg_check_en(cfg_check_en), .cfg_golden_crc(cfg_golden_crc),
        .bus(bus_if.master),
        .busy(busy), .state_o(state_o), .frames_done(frames_done),
        .mismatch_count(mismatch_count), .crc_last(crc_last), .crc_ok(crc_ok),
        .timeout_flag(timeout_flag), .irq_pulse(irq_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      crc;
        logic             ok;
        logic [CNT_W-1:0] mm;
        logic [CNT_W-1:0] fd;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               rs_count = 0;
    int               irq_count = 0;
    bit               chk_next = 1'b0;
    logic [CNT_W-1:0] m_frames = '0;
    logic [CNT_W-1:0] m_mm = '0;

    // Completed frames are compared the cycle after DONE, once the result registers settle.
    always @(negedge clk) begin
        exp_t e;
        if (chk_next) begin
            chk_next = 1'b0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected completion, frames_done=%0d", frames_done);
            end else begin
                e = sb.pop_front();
                if ({crc_last, crc_ok, mismatch_count, frames_done} !== {e.crc, e.ok, e.mm, e.fd}) begin
                    errors++;
                    $display("FAIL frame_result: got crc_last=%h ok=%b mm=%0d fd=%0d, want crc_last=%h ok=%b mm=%0d fd=%0d",
                             crc_last, crc_ok, mismatch_count, frames_done, e.crc, e.ok, e.mm, e.fd);
                end
            end
        end
        if (bus_if.render_start) rs_count++;
        if (irq_pulse) irq_count++;
        if (irq_pulse && state_o == 3'd4) chk_next = 1'b1;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, state=%0d", state_o);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step(); bus_if.start_req = 1'b1;
        step(); bus_if.start_req = 1'b0;
    endtask

    task automatic pulse_abort();
        step(); bus_if.abort_req = 1'b1;
        step(); bus_if.abort_req = 1'b0;
        m_frames = '0;
        m_mm     = '0;
    endtask

    task automatic push_frame(input logic [31:0] crc);
        exp_t e;
        logic ok;
        ok = cfg_check_en ? (crc == cfg_golden_crc) : 1'b1;
        m_frames = m_frames + 1'b1;
        if (!ok && m_mm != '1) m_mm = m_mm + 1'b1;
        e.crc = crc; e.ok = ok; e.mm = m_mm; e.fd = m_frames;
        sb.push_back(e);
    endtask

    // Answers one launch: render_done rd cycles and crc_valid cv cycles after render_start.
    task automatic serve(input int rd, input int cv, input logic [31:0] crc, input bit drop_en);
        int n = 0;
        int last;
        push_frame(crc);
        while (!bus_if.render_start && n < 50) begin step(); n++; end
        if (!bus_if.render_start) begin
            checks++; errors++;
            $display("FAIL no_launch: render_start=%b after %0d cycles, want 1", bus_if.render_start, n);
            void'(sb.pop_back());
            m_frames = m_frames - 1'b1;
            return;
        end
        if (drop_en) cfg_enable = 1'b0;
        last = (rd > cv) ? rd : cv;
        for (int t = 1; t <= last; t++) begin
            step();
            bus_if.render_done = (t == rd);
            bus_if.crc_valid   = (t == cv);
            bus_if.crc_in      = crc;
        end
        step();
        bus_if.render_done = 1'b0;
        bus_if.crc_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (state_o !== 3'd0 && n < 100) begin step(); n++; end
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL wait_idle: state=%0d, want 0", state_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_enable = 1'b1; cfg_continuous = 1'b0; cfg_frame_budget = '0;
        cfg_timeout = '0; cfg_check_en = 1'b1; cfg_golden_crc = GOLDEN;
        bus_if.start_req = 1'b0; bus_if.abort_req = 1'b0;
        bus_if.render_done = 1'b0; bus_if.crc_valid = 1'b0; bus_if.crc_in = '0;
        repeat (3) step();
        checks++;
        if ({state_o, busy, frames_done, mismatch_count, crc_last, crc_ok, timeout_flag, irq_pulse, bus_if.render_start}
            !== {3'd0, 1'b0, 16'd0, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: state=%0d busy=%b fd=%0d mm=%0d crc_last=%h ok=%b to=%b irq=%b rs=%b, want 0 0 0 0 0 1 0 0 0",
                     state_o, busy, frames_done, mismatch_count, crc_last, crc_ok, timeout_flag, irq_pulse, bus_if.render_start);
        end
        rst = 1'b0;
        step();
        cfg_enable = 1'b0;
        pulse_start();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL start_disabled: state=%0d, want 0", state_o);
        end
        cfg_enable = 1'b1;
    endtask

    task automatic test_single();
        rs_count = 0; irq_count = 0;
        pulse_start();
        checks++;
        if (bus_if.render_start !== 1'b1) begin
            errors++;
            $display("FAIL launch_latency: render_start=%b one cycle after start_req, want 1", bus_if.render_start);
        end
        serve(100, 300, GOLDEN, 1'b0);
        wait_idle();
        checks++;
        if (rs_count !== 1 || irq_count !== 1) begin
            errors++;
            $display("FAIL single_pulses: render_start=%0d irq=%0d, want 1 1", rs_count, irq_count);
        end
    endtask

    task automatic test_mismatch();
        pulse_start();
        serve(100, 300, 32'h0002_0501, 1'b0);
        wait_idle();
        checks++;
        if (crc_ok !== 1'b0 || mismatch_count !== 16'd1 || crc_last !== 32'h0002_0501) begin
            errors++;
            $display("FAIL mismatch: ok=%b mm=%0d crc_last=%h, want 0 1 00020501", crc_ok, mismatch_count, crc_last);
        end
        cfg_check_en = 1'b0;
        pulse_start();
        serve(4, 8, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        cfg_check_en = 1'b1;
    endtask

    task automatic test_continuous();
        int rs0;
        pulse_abort();
        cfg_continuous = 1'b1; cfg_frame_budget = 16'd3;
        rs0 = rs_count;
        pulse_start();
        for (int i = 0; i < 3; i++) serve(4, 6, GOLDEN, 1'b0);
        wait_idle();
        repeat (10) step();
        checks++;
        if (rs_count - rs0 !== 3 || frames_done !== 16'd3) begin
            errors++;
            $display("FAIL budget_run: launches=%0d fd=%0d, want 3 3", rs_count - rs0, frames_done);
        end
        pulse_abort();
        cfg_frame_budget = '0;
        rs0 = rs_count;
        pulse_start();
        for (int i = 0; i < 4; i++) serve(3, 5, GOLDEN ^ 32'(i), 1'b0);
        serve(3, 5, GOLDEN, 1'b1);
        wait_idle();
        repeat (10) step();
        checks++;
        if (rs_count - rs0 !== 5 || frames_done !== 16'd5) begin
            errors++;
            $display("FAIL unlimited_stop: launches=%0d fd=%0d, want 5 5", rs_count - rs0, frames_done);
        end
        cfg_enable = 1'b1; cfg_continuous = 1'b0;
    endtask

    task automatic test_ordering();
        pulse_start();
        serve(10, 5, 32'h1234_5678, 1'b0);
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL crc_first_done: state=%0d on render_done cycle, want 4", state_o);
        end
        wait_idle();
        pulse_start();
        serve(7, 7, GOLDEN, 1'b0);
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL same_cycle_done: state=%0d, want 4", state_o);
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        int n = 0;
        cfg_timeout = 24'd50;
        irq_count = 0;
        pulse_start();
        step();
        while (state_o === 3'd2 && n < 200) begin n++; step(); end
        checks++;
        if (n !== 50 || state_o !== 3'd5 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_entry: cycles=%0d state=%0d flag=%b, want 50 5 1", n, state_o, timeout_flag);
        end
        repeat (5) step();
        checks++;
        if (irq_count !== 1 || state_o !== 3'd5) begin
            errors++;
            $display("FAIL timeout_irq: irq=%0d state=%0d, want 1 5", irq_count, state_o);
        end
        pulse_start();
        checks++;
        if (timeout_flag !== 1'b0 || bus_if.render_start !== 1'b1) begin
            errors++;
            $display("FAIL error_relaunch: flag=%b render_start=%b, want 0 1", timeout_flag, bus_if.render_start);
        end
        serve(3, 5, GOLDEN, 1'b0);
        wait_idle();
        pulse_start();
        serve(50, 50, GOLDEN, 1'b0);
        checks++;
        if (state_o !== 3'd4 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL expiry_tie: state=%0d flag=%b, want 4 0", state_o, timeout_flag);
        end
        wait_idle();
        cfg_timeout = '0;
    endtask

    task automatic test_abort();
        int irq0;
        pulse_abort();
        pulse_start();
        serve(2, 4, GOLDEN, 1'b0);
        wait_idle();
        pulse_start();
        serve(2, 4, 32'hCAFE_0001, 1'b0);
        wait_idle();
        pulse_start();
        step(); bus_if.render_done = 1'b1;
        step(); bus_if.render_done = 1'b0;
        checks++;
        if (state_o !== 3'd3 || frames_done !== 16'd2) begin
            errors++;
            $display("FAIL pre_abort: state=%0d fd=%0d, want 3 2", state_o, frames_done);
        end
        irq0 = irq_count;
        pulse_abort();
        checks++;
        if (state_o !== 3'd0 || frames_done !== '0 || mismatch_count !== '0 || crc_ok !== 1'b1 ||
            crc_last !== 32'hCAFE_0001 || irq_pulse !== 1'b0 || irq_count !== irq0) begin
            errors++;
            $display("FAIL abort_clear: state=%0d fd=%0d mm=%0d ok=%b crc_last=%h irq=%b irqs=%0d, want 0 0 0 1 cafe0001 0 %0d",
                     state_o, frames_done, mismatch_count, crc_ok, crc_last, irq_pulse, irq_count, irq0);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        checks++;
        if (bus_if.render_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: render_start=%b, want 1", bus_if.render_start);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus_if.render_start !== 1'b0 || state_o !== 3'd0) begin
            errors++;
            $display("FAIL async_rst: render_start=%b state=%0d mid-cycle, want 0 0", bus_if.render_start, state_o);
        end
        step();
        rst = 1'b0;
        m_frames = '0; m_mm = '0;
        step();
        checks++;
        if (frames_done !== '0 || crc_last !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: fd=%0d crc_last=%h busy=%b, want 0 0 0", frames_done, crc_last, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_continuous();
        test_ordering();
        test_timeout();
        test_abort();
        test_async_reset();
        repeat (3) step();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected frames never completed, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_frame_scheduler.md
Name: hdmi_frame_scheduler

Overview:
Sequences render/scan-out frames for the voxel pipeline. It launches the renderer, waits for render completion and the HDMI sink's end-of-frame CRC, and checks that CRC against a programmed golden value. It also enforces a per-frame watchdog and raises an interrupt per frame or fault. It sits between the AXI-Lite register block (CTRL/config fields) and the renderer/HDMI stream monitor, replacing ad-hoc start_frame/auto-start wiring.

Parameters:
TIMEOUT_W, 24, width of the watchdog counter and cfg_timeout
CNT_W, 16, width of frame budget, frame counter and mismatch counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_enable  in  1  scheduler enable; 0 blocks new launches
cfg_continuous  in  1  1 = relaunch automatically after each frame
cfg_frame_budget  in  CNT_W  frames per run in continuous mode; 0 = unlimited
cfg_timeout  in  TIMEOUT_W  watchdog limit in cycles; 0 = disabled
cfg_check_en  in  1  enable CRC compare
cfg_golden_crc  in  32  expected frame CRC
start_req  in  1  one-cycle pulse, CTRL start_frame
abort_req  in  1  one-cycle pulse, CTRL soft_reset
render_start  out  1  one-cycle pulse to renderer
render_done  in  1  one-cycle pulse from renderer
crc_valid  in  1  one-cycle pulse from HDMI sink at frame end
crc_in  in  32  frame CRC, qualified by crc_valid
busy  out  1  state not IDLE/ERROR
state_o  out  3  encoded FSM state
frames_done  out  CNT_W  completed frames since reset/abort
mismatch_count  out  CNT_W  CRC mismatches since reset/abort
crc_last  out  32  last captured CRC
crc_ok  out  1  last compare result (1 if check disabled)
timeout_flag  out  1  sticky watchdog expiry
irq_pulse  out  1  one-cycle interrupt

Behaviour:
- Reset values: all outputs 0; state IDLE; crc_ok 1; internal run_count 0; crc_pending 0.
- States (encoding): IDLE=0, LAUNCH=1, WAIT_RENDER=2, WAIT_SCAN=3, DONE=4, ERROR=5.
- IDLE: on start_req & cfg_enable, go to LAUNCH and clear run_count. start_req with cfg_enable=0 is ignored.
- LAUNCH: lasts exactly 1 cycle; render_start=1; watchdog loaded to 0; go to WAIT_RENDER. render_start is asserted the cycle after start_req is sampled.
- WAIT_RENDER: on render_done, go to WAIT_SCAN, or directly to DONE if crc_pending or crc_valid is seen the same cycle. A crc_valid arriving before render_done sets crc_pending and latches crc_in.
- WAIT_SCAN: on crc_valid, latch crc_in and go to DONE.
- DONE: lasts 1 cycle; irq_pulse=1; frames_done+1 and run_count+1 (both wrap modulo 2^CNT_W); crc_last updated.
  - If cfg_check_en: crc_ok = (crc==cfg_golden_crc), and mismatch_count+1 (saturating) on inequality.
  - crc_pending cleared.
  - Next state is LAUNCH if cfg_continuous & cfg_enable & (cfg_frame_budget==0 | run_count+1 < cfg_frame_budget); otherwise IDLE.
- Watchdog: increments each cycle in WAIT_RENDER/WAIT_SCAN. When cfg_timeout≠0 and count==cfg_timeout-1 with no completing event that cycle: go to ERROR, set timeout_flag, irq_pulse=1 on entry. A completing event on the expiry cycle wins over the timeout.
- ERROR: stays until start_req (clears timeout_flag; goes to LAUNCH if cfg_enable, else IDLE) or abort_req.
- abort_req: highest priority in any state. Next cycle state=IDLE; frames_done, mismatch_count, run_count, crc_pending, timeout_flag cleared; crc_ok=1; crc_last held; no irq_pulse or render_start.
- start_req while busy is ignored; it is not queued.
- cfg_enable deasserted mid-frame: the current frame completes normally, then DONE goes to IDLE.
- render_done/crc_valid in IDLE, LAUNCH or ERROR are ignored. Exception: a crc_valid in LAUNCH sets crc_pending.
- cfg_* inputs are sampled live; software must change them only while idle.
- Async rst mid-frame: immediate return to reset values; render_start deasserts combinationally with the state flop.

Test Plan:
- Single frame, check on: cfg_golden_crc=0x00020500, start_req; render_done at +100, crc_valid(0x00020500) at +300 -> one render_start pulse 1 cycle after start; DONE irq; frames_done=1, crc_ok=1, mismatch_count=0; state returns IDLE.
- Mismatch: same sequence with crc_in=0x00020501 -> crc_ok=0, mismatch_count=1, crc_last=0x00020501.
- Continuous budget: cfg_continuous=1, budget=3, each frame answered -> exactly 3 render_start pulses; frames_done=3; IDLE afterwards. Repeat with budget=0 and deassert cfg_enable during frame 5 -> stops after frame 5.
- Ordering: crc_valid before render_done, then both in the same cycle -> each frame goes to DONE on render_done's cycle; no frame is lost.
- Timeout: cfg_timeout=50, render_done never sent -> ERROR after exactly 50 cycles in WAIT_RENDER, timeout_flag=1, one irq; a second start_req relaunches and clears the flag.
- Abort/reset: abort_req in WAIT_SCAN with frames_done=2 -> IDLE next cycle, counters 0, no irq. Async rst pulse mid-LAUNCH -> render_start drops immediately.
